// File: rtl/counter_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : counter_sequencer
//  Purpose  : Command-driven sequencer around a free-running counter. Accepts
//             START / STOP / PAUSE / RESUME on a valid/ready interface and
//             produces a sequenced count, a one-cycle terminal-count tick and
//             a saturating count of completed periods.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock         in   system clock, rising-edge active
//    reset         in   asynchronous active-high reset
//    cmd_valid     in   command present
//    cmd_ready     out  command accepted this cycle if cmd_valid is high
//    cmd_op        in   00 START, 01 STOP, 10 PAUSE, 11 RESUME
//    cmd_limit     in   terminal count, sampled on accepted START
//    cmd_periodic  in   1 periodic / 0 one-shot, sampled on accepted START
//    count         out  current counter value
//    state         out  0 IDLE, 1 LOAD, 2 RUN, 3 PAUSE, 4 DONE
//    busy          out  high in LOAD, RUN or PAUSE
//    tick          out  one-cycle pulse on terminal count
//    periods       out  completed periods since last START, saturating
// ============================================================================
module counter_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_limit,
   input  logic             cmd_periodic,
   output logic [WIDTH-1:0] count,
   output logic [2:0]       state,
   output logic             busy,
   output logic             tick,
   output logic [WIDTH-1:0] periods
);

   localparam logic [1:0]       c_OP_START  = 2'b00;
   localparam logic [1:0]       c_OP_STOP   = 2'b01;
   localparam logic [1:0]       c_OP_PAUSE  = 2'b10;
   localparam logic [1:0]       c_OP_RESUME = 2'b11;
   localparam logic [WIDTH-1:0] c_ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_RUN   = 3'd2,
      S_PAUSE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] r_limit;
   logic [WIDTH-1:0] r_periods;
   logic             r_periodic;
   logic             r_tick;
   logic             r_busy;

   logic             w_accept;
   logic             w_start;
   logic             w_stop;
   logic             w_pause;
   logic             w_resume;

   // LOAD is the only state that refuses commands.
   assign cmd_ready = (r_state != S_LOAD);
   assign w_accept  = cmd_valid && cmd_ready;

   // PAUSE and RESUME only act in RUN and PAUSE respectively; elsewhere they
   // are consumed without effect and normal sequencing continues.
   assign w_start  = w_accept && (cmd_op == c_OP_START);
   assign w_stop   = w_accept && (cmd_op == c_OP_STOP);
   assign w_pause  = w_accept && (cmd_op == c_OP_PAUSE)  && (r_state == S_RUN);
   assign w_resume = w_accept && (cmd_op == c_OP_RESUME) && (r_state == S_PAUSE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_count    <= '0;
         r_limit    <= '0;
         r_periods  <= '0;
         r_periodic <= 1'b0;
         r_tick     <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_tick <= 1'b0;
         // An effective command always wins over terminal-count handling,
         // which is how a colliding STOP/START/PAUSE suppresses the tick.
         if (w_start) begin
            r_limit    <= cmd_limit;
            r_periodic <= cmd_periodic;
            r_state    <= S_LOAD;
            r_busy     <= 1'b1;
            r_count    <= '0;
            r_periods  <= '0;
         end else if (w_stop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_count <= '0;
         end else if (w_pause) begin
            r_state <= S_PAUSE;
         end else if (w_resume) begin
            r_state <= S_RUN;
         end else begin
            case (r_state)
               S_LOAD: begin
                  r_state <= S_RUN;
                  r_count <= '0;
               end
               S_RUN: begin
                  if (r_count < r_limit) begin
                     r_count <= r_count + c_ONE;
                  end else begin
                     r_tick <= 1'b1;
                     if (!(&r_periods)) begin
                        r_periods <= r_periods + c_ONE;
                     end
                     if (r_periodic) begin
                        r_count <= '0;
                     end else begin
                        // One-shot: count parks at the limit in DONE.
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                     end
                  end
               end
               default: begin
                  // IDLE, PAUSE and DONE hold everything.
               end
            endcase
         end
      end
   end

   assign count   = r_count;
   assign state   = r_state;
   assign busy    = r_busy;
   assign tick    = r_tick;
   assign periods = r_periods;

endmodule
`default_nettype wire

// File: tb/tb_counter_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_counter_sequencer
//  Purpose  : Self-checking bench for counter_sequencer. A behavioural model
//             tracks the expected outputs cycle by cycle; directed scenarios
//             add literal expectations for one-shot, periodic, pause/resume,
//             collision, saturation, blocked START and asynchronous reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_counter_sequencer;

   localparam int WIDTH = 8;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [1:0]       cmd_op = 2'b00;
   logic [WIDTH-1:0] cmd_limit = '0;
   logic             cmd_periodic = 1'b0;
   logic [WIDTH-1:0] count;
   logic [2:0]       state;
   logic             busy;
   logic             tick;
   logic [WIDTH-1:0] periods;

   counter_sequencer #(.WIDTH(WIDTH)) dut (
      .clock        (clock),
      .reset        (reset),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_limit    (cmd_limit),
      .cmd_periodic (cmd_periodic),
      .count        (count),
      .state        (state),
      .busy         (busy),
      .tick         (tick),
      .periods      (periods)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // Behavioural model: states 0 IDLE, 1 LOAD, 2 RUN, 3 PAUSE, 4 DONE.
   // ------------------------------------------------------------------
   int m_state   = 0;
   int m_count   = 0;
   int m_periods = 0;
   int m_limit   = 0;
   bit m_per     = 0;
   bit m_tick    = 0;
   bit m_acc;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_state = 0; m_count = 0; m_periods = 0; m_limit = 0; m_per = 0; m_tick = 0;
      end else begin
         m_acc  = cmd_valid && (m_state != 1);
         m_tick = 0;
         if (m_acc && cmd_op == 2'b00) begin
            m_limit = int'(cmd_limit); m_per = cmd_periodic;
            m_state = 1; m_count = 0; m_periods = 0;
         end else if (m_acc && cmd_op == 2'b01) begin
            m_state = 0; m_count = 0;
         end else if (m_acc && cmd_op == 2'b10 && m_state == 2) begin
            m_state = 3;
         end else if (m_acc && cmd_op == 2'b11 && m_state == 3) begin
            m_state = 2;
         end else if (m_state == 1) begin
            m_state = 2; m_count = 0;
         end else if (m_state == 2) begin
            if (m_count < m_limit) m_count = m_count + 1;
            else begin
               m_tick    = 1;
               m_periods = (m_periods < 255) ? m_periods + 1 : 255;
               if (m_per) m_count = 0;
               else       m_state = 4;
            end
         end
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clock) begin
      if (!reset) begin
         chk("cmp_count",   32'(count),     32'(m_count));
         chk("cmp_state",   32'(state),     32'(m_state));
         chk("cmp_tick",    32'(tick),      32'(m_tick));
         chk("cmp_periods", 32'(periods),   32'(m_periods));
         chk("cmp_busy",    32'(busy),      32'(m_state >= 1 && m_state <= 3));
         chk("cmp_ready",   32'(cmd_ready), 32'(m_state != 1));
      end
   end

   // Present a command at a negedge; returns at the negedge after acceptance.
   task automatic send(input logic [1:0] op, input int lim, input bit per);
      bit done = 0;
      cmd_valid = 1'b1; cmd_op = op; cmd_limit = lim[7:0]; cmd_periodic = per;
      for (int i = 0; i < 8 && !done; i++) begin
         done = cmd_ready;
         @(negedge clock);
      end
      cmd_valid = 1'b0;
      chk("send_accept", 32'(done), 32'd1);
   endtask

   task automatic wait_count(input int c);
      bit hit = 0;
      for (int i = 0; i < 400 && !hit; i++) begin
         @(negedge clock);
         hit = (m_state == 2 && m_count == c);
      end
      chk("wait_count", 32'(hit), 32'd1);
   endtask

   task automatic wait_tick(output int when);
      bit hit = 0;
      when = -1;
      for (int i = 0; i < 100 && !hit; i++) begin
         @(negedge clock);
         hit = tick;
      end
      when = cyc;
      chk("wait_tick", 32'(hit), 32'd1);
   endtask

   int exp_s [7] = '{1, 2, 2, 2, 2, 4, 4};
   int exp_c [7] = '{0, 0, 1, 2, 3, 3, 3};
   int exp_t [7] = '{0, 0, 0, 0, 0, 1, 0};

   initial begin
      int nt, first, t1, t2, pexp;

      repeat (3) @(negedge clock);
      reset = 1'b0;
      chk("rst_state",   32'(state),     32'd0);
      chk("rst_count",   32'(count),     32'd0);
      chk("rst_tick",    32'(tick),      32'd0);
      chk("rst_periods", 32'(periods),   32'd0);
      chk("rst_busy",    32'(busy),      32'd0);
      chk("rst_ready",   32'(cmd_ready), 32'd1);
      @(negedge clock);

      // One-shot, limit 3.
      send(2'b00, 3, 1'b0);
      for (int i = 0; i < 7; i++) begin
         chk($sformatf("os_state%0d", i), 32'(state), 32'(exp_s[i]));
         chk($sformatf("os_count%0d", i), 32'(count), 32'(exp_c[i]));
         chk($sformatf("os_tick%0d", i),  32'(tick),  32'(exp_t[i]));
         if (i == 0) chk("os_ready_load", 32'(cmd_ready), 32'd0);
         if (i == 1) chk("os_ready_run",  32'(cmd_ready), 32'd1);
         @(negedge clock);
      end
      chk("os_periods", 32'(periods), 32'd1);
      chk("os_done",    32'(state),   32'd4);
      chk("os_hold",    32'(count),   32'd3);

      // STOP from DONE keeps periods; PAUSE in IDLE is ignored.
      send(2'b01, 0, 1'b0);
      chk("stop_state",   32'(state),   32'd0);
      chk("stop_periods", 32'(periods), 32'd1);
      send(2'b10, 0, 1'b0);
      chk("idle_pause_state", 32'(state), 32'd0);
      chk("idle_pause_busy",  32'(busy),  32'd0);

      // Periodic, limit 4: ticks at START+6, +11, +16, +21.
      send(2'b00, 4, 1'b1);
      nt = 0; first = -1;
      for (int i = 1; i <= 21; i++) begin
         @(negedge clock);
         if (tick) begin
            nt++;
            if (first < 0) first = i;
         end
      end
      chk("per_ticks",   32'(nt),      32'd4);
      chk("per_first",   32'(first),   32'd6);
      chk("per_periods", 32'(periods), 32'd4);

      // RESUME while running is ignored.
      send(2'b11, 0, 1'b0);
      chk("run_resume_state", 32'(state), 32'd2);

      // STOP colliding with terminal count.
      wait_count(4);
      pexp = m_periods;
      send(2'b01, 0, 1'b0);
      chk("coll_state",   32'(state),   32'd0);
      chk("coll_count",   32'(count),   32'd0);
      chk("coll_tick",    32'(tick),    32'd0);
      chk("coll_periods", 32'(periods), 32'(pexp));

      // Pause/resume, limit 9: pause 7 cycles inside the second period.
      send(2'b00, 9, 1'b1);
      wait_tick(t1);
      wait_count(6);
      send(2'b10, 0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("pause_count%0d", i), 32'(count), 32'd6);
         chk($sformatf("pause_tick%0d", i),  32'(tick),  32'd0);
         chk($sformatf("pause_state%0d", i), 32'(state), 32'd3);
         @(negedge clock);
      end
      send(2'b11, 0, 1'b0);
      chk("resume_state", 32'(state), 32'd2);
      chk("resume_count", 32'(count), 32'd6);
      wait_tick(t2);
      chk("pause_spacing", 32'(t2 - t1), 32'd18);

      // Saturation with limit 0 periodic.
      send(2'b01, 0, 1'b0);
      send(2'b00, 0, 1'b1);
      repeat (300) @(negedge clock);
      chk("sat_periods", 32'(periods), 32'd255);
      chk("sat_tick",    32'(tick),    32'd1);
      chk("sat_count",   32'(count),   32'd0);

      // START held through LOAD is only re-accepted once LOAD is over.
      send(2'b01, 0, 1'b0);
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_limit = 8'd2; cmd_periodic = 1'b0;
      @(negedge clock);
      chk("hold_load1", 32'(state), 32'd1);
      @(negedge clock);
      chk("hold_run",   32'(state), 32'd2);
      chk("hold_count", 32'(count), 32'd0);
      @(negedge clock);
      chk("hold_load2", 32'(state), 32'd1);
      cmd_valid = 1'b0;

      // Asynchronous reset mid-run at count 5.
      send(2'b00, 9, 1'b0);
      wait_count(5);
      #2 reset = 1'b1;
      #1;
      chk("arst_count",   32'(count),     32'd0);
      chk("arst_state",   32'(state),     32'd0);
      chk("arst_tick",    32'(tick),      32'd0);
      chk("arst_periods", 32'(periods),   32'd0);
      chk("arst_busy",    32'(busy),      32'd0);
      chk("arst_ready",   32'(cmd_ready), 32'd1);
      @(negedge clock);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      chk("post_rst_state", 32'(state), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Controls a free-running counter datapath. It is driven by command transactions on a valid/ready interface: START (with a terminal limit and a mode), STOP, PAUSE and RESUME.
- Produces the sequenced count value, a one-cycle terminal-count tick, and a saturating count of completed periods.
- Sits between a host or CSR block and any consumer that needs programmable periodic or one-shot timing.

Parameters:
- WIDTH, 8, width of count, limit and period counter.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command can be accepted this cycle.
- cmd_op  in  2  00 START, 01 STOP, 10 PAUSE, 11 RESUME.
- cmd_limit  in  WIDTH  terminal value; sampled only on accepted START.
- cmd_periodic  in  1  1 = periodic, 0 = one-shot; sampled only on accepted START.
- count  out  WIDTH  current counter value.
- state  out  3  0 IDLE, 1 LOAD, 2 RUN, 3 PAUSE, 4 DONE.
- busy  out  1  high in LOAD, RUN or PAUSE.
- tick  out  1  registered one-cycle pulse on terminal count.
- periods  out  WIDTH  completed periods since last START; saturates at 2^WIDTH-1.

Behaviour:
- Reset values: state=IDLE, count=0, tick=0, periods=0, busy=0, cmd_ready=1. Internal limit=0, periodic=0. Reset asserted mid-operation aborts immediately to these values.
- Handshake: a command is accepted on a rising edge with cmd_valid && cmd_ready. cmd_ready = (state != LOAD). cmd_op, cmd_limit and cmd_periodic must be stable while cmd_valid is high.
- START, accepted in any state except LOAD:
  - latches limit and periodic;
  - next state LOAD; count=0, periods=0, tick=0.
- LOAD:
  - lasts exactly one cycle, then RUN with count=0;
  - no command is accepted.
- RUN:
  - count < limit: count increments by 1 per cycle.
  - count == limit, periodic: next count=0, tick=1 for one cycle, periods += 1 (saturating); stay in RUN.
  - count == limit, one-shot: next state DONE, count holds at limit, tick=1 for one cycle, periods=1.
- Timing: START accepted at edge N gives LOAD after N and count=0 (RUN) after N+1. count=L after N+1+L; tick=1 after N+2+L. Periodic tick period = L+1 cycles.
- limit=0: periodic ticks every cycle from the second RUN cycle on; one-shot goes to DONE one cycle after entering RUN.
- count never exceeds limit, so no arithmetic wrap. periods holds at all-ones once saturated.
- PAUSE: accepted in RUN → PAUSE; count, periods and limit are frozen, tick=0. In any other state it is accepted and ignored.
- RESUME: accepted in PAUSE → RUN; counting continues from the frozen count on the next cycle. In any other state it is accepted and ignored.
- STOP: accepted in any ready state → IDLE, count=0, tick=0; periods holds its value.
- DONE: holds until START (restart) or STOP (→IDLE).
- Command vs terminal count in the same cycle: the command has priority.
  - STOP, START or PAUSE accepted while count==limit in RUN suppresses that tick and periods increment.
  - PAUSE freezes count at limit; the tick fires one cycle after RESUME.
- tick is never high for two consecutive cycles unless periodic with limit=0.
- busy = state ∈ {LOAD, RUN, PAUSE}, registered with state.

Test Plan:
- Reset: assert reset asynchronously mid-RUN with count=5 → count, tick, periods go to 0 and state=IDLE before the next clock edge; cmd_ready=1.
- One-shot: START limit=3, periodic=0 → cmd_ready=0 for one cycle; count sequence 0,1,2,3; tick=1 for exactly one cycle; state=DONE, count stays 3, periods=1.
- Periodic: START limit=4, periodic=1, run 20 cycles → tick every 5 cycles, count wraps 4→0; periods=4 after the fourth tick. With WIDTH=8, limit=0 for 300 cycles → periods saturates at 255.
- Pause/resume: periodic limit=9, PAUSE at count=6, hold 7 cycles → count stays 6, no tick. RESUME → count 7,8,9, then tick; total tick spacing 10 + 7 + 1 cycles.
- Collision: STOP presented exactly when count==limit → no tick, state=IDLE, count=0, periods unchanged.
- Ignored and blocked commands: PAUSE in IDLE and RESUME in RUN → accepted, no state change. START held during LOAD → not accepted until the following cycle.
